// File: rtl/sevenseg_pkg.sv
// Shared definitions for seven-segment display capture: segment patterns,
// FSM state encoding and the pattern/strobe decode helpers.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // Returns {legal, bcd}; blank and every non-digit pattern are illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            SEG_0:   r = {1'b1, 4'd0};
            SEG_1:   r = {1'b1, 4'd1};
            SEG_2:   r = {1'b1, 4'd2};
            SEG_3:   r = {1'b1, 4'd3};
            SEG_4:   r = {1'b1, 4'd4};
            SEG_5:   r = {1'b1, 4'd5};
            SEG_6:   r = {1'b1, 4'd6};
            SEG_7:   r = {1'b1, 4'd7};
            SEG_8:   r = {1'b1, 4'd8};
            SEG_9:   r = {1'b1, 4'd9};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic an_onehot(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    function automatic logic [1:0] an_pos(input logic [3:0] a);
        logic [1:0] p;
        case (a)
            4'b1101: p = 2'd1;
            4'b1011: p = 2'd2;
            4'b0111: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg2bcd.sv
// Combinational seven-segment pattern to BCD lookup.
module seg2bcd
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        {legal, bcd} = seg_decode(seg);
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures the four digits shown on a multiplexed seven-segment display once
// each segment/anode pair has been stable for STABLE_CYCLES sampled cycles.
//
//   state     | meaning
//   ST_IDLE   | sampled strobe not one-hot, nothing to track
//   ST_SETTLE | one-hot strobe seen, counting stable cycles
//   ST_HELD   | value captured, waiting for the pins to change
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_pos
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [3:0] an_s, an_p;
    logic [6:0] seg_s, seg_p;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] mask;
    logic       capture;
    logic       same;
    logic       onehot;
    logic [1:0] pos;
    logic [3:0] mask_set;
    logic [3:0] dec_bcd;
    logic       dec_legal;

    seg2bcd u_dec (
        .seg   (seg_s),
        .bcd   (dec_bcd),
        .legal (dec_legal)
    );

    // Second stage holds last cycle's sample so stability is judged on sampled values only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s  <= 4'b1111;
            seg_s <= 7'd0;
            an_p  <= 4'b1111;
            seg_p <= 7'd0;
        end else begin
            an_s  <= an;
            seg_s <= seg;
            an_p  <= an_s;
            seg_p <= seg_s;
        end
    end

    assign same     = ({an_s, seg_s} == {an_p, seg_p});
    assign onehot   = an_onehot(an_s);
    assign pos      = an_pos(an_s);
    assign mask_set = mask | ~an_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (onehot) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 4'd1;
                end else begin
                    cnt_n = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (!onehot) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else if (!same) begin
                    cnt_n = 4'd1;
                end else begin
                    cnt_n = (cnt < CNT_MAX) ? cnt + 4'd1 : CNT_MAX;
                    if (cnt_n == CNT_MAX) begin
                        capture = 1'b1;
                        state_n = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!same) begin
                    if (onehot) begin
                        state_n = ST_SETTLE;
                        cnt_n   = 4'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = 4'd0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 16'd0;
            digit_valid <= 4'd0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_pos     <= 2'd0;
            mask        <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (capture) begin
                if (dec_legal) begin
                    digits[{pos, 2'b00} +: 4] <= dec_bcd;
                    digit_valid[pos]          <= 1'b1;
                    if (mask_set == 4'b1111) begin
                        frame_done <= 1'b1;
                        mask       <= 4'd0;
                    end else begin
                        mask <= mask_set;
                    end
                end else begin
                    digit_valid[pos] <= 1'b0;
                    err              <= 1'b1;
                    err_pos          <= pos;
                    mask             <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: expected output events are queued as
// stimulus is applied and matched, including their cycle, when the DUT reacts.
module tb_sevenseg_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_pos;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [3:0]  v;
        logic        fd;
        logic        er;
        logic [1:0]  ep;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] last_d;
    logic [3:0]  last_v;

    sevenseg_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_pos     (err_pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_d = digits;
            last_v = digit_valid;
        end else if (err || frame_done || digits !== last_d || digit_valid !== last_v) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_event cyc=%0d digits=%h valid=%b err=%b fd=%b",
                         cyc, digits, digit_valid, err, frame_done);
            end else begin
                mon_e = sb.pop_front();
                total++;
                if (cyc !== mon_e.cyc) begin
                    bad++; $display("FAIL event_cycle got=%0d want=%0d", cyc, mon_e.cyc);
                end
                total++;
                if (digits !== mon_e.d) begin
                    bad++; $display("FAIL digits got=%h want=%h", digits, mon_e.d);
                end
                total++;
                if (digit_valid !== mon_e.v) begin
                    bad++; $display("FAIL digit_valid got=%b want=%b", digit_valid, mon_e.v);
                end
                total++;
                if (frame_done !== mon_e.fd) begin
                    bad++; $display("FAIL frame_done got=%b want=%b", frame_done, mon_e.fd);
                end
                total++;
                if (err !== mon_e.er) begin
                    bad++; $display("FAIL err got=%b want=%b", err, mon_e.er);
                end
                total++;
                if (err_pos !== mon_e.ep) begin
                    bad++; $display("FAIL err_pos got=%0d want=%0d", err_pos, mon_e.ep);
                end
            end
            last_d = digits;
            last_v = digit_valid;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int at, input logic [15:0] d, input logic [3:0] v,
                        input logic fd, input logic er, input logic [1:0] ep);
        ev_t e;
        e.cyc = at; e.d = d; e.v = v; e.fd = fd; e.er = er; e.ep = ep;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (digits !== 16'h0000) begin bad++; $display("FAIL rst_digits got=%h want=0000", digits); end
        total++;
        if (digit_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b want=0000", digit_valid); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b want=0", frame_done); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        total++;
        if (err_pos !== 2'd0) begin bad++; $display("FAIL rst_err_pos got=%0d want=0", err_pos); end
        rst_n = 1'b1;
        hold(4'b1111, 7'h00, 2);
    endtask

    task automatic test_single();
        push(cyc + S + 1, 16'h0000, 4'b0001, 1'b0, 1'b0, 2'd0);
        hold(4'b1110, 7'h7E, 6);
        hold(4'b1111, 7'h00, 3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL single_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_scan();
        logic [3:0]  a[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0]  s[4]  = '{7'h79, 7'h30, 7'h6D, 7'h7B};
        logic [15:0] d[4]  = '{16'h0003, 16'h0013, 16'h0213, 16'h9213};
        logic [3:0]  v[4]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        logic        fd[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            push(cyc + S + 1, d[i], v[i], fd[i], 1'b0, 2'd0);
            hold(a[i], s[i], 8);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scan_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_illegal();
        logic [3:0]  a[6]  = '{4'b1110, 4'b1011, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [6:0]  s[6]  = '{7'h5B, 7'h45, 7'h33, 7'h5F, 7'h70, 7'h7F};
        logic [15:0] d[6]  = '{16'h9215, 16'h9215, 16'h9245, 16'h9645, 16'h7645, 16'h7648};
        logic [3:0]  v[6]  = '{4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111};
        logic        fd[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        er[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  ep[6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        for (int i = 0; i < 6; i++) begin
            push(cyc + S + 1, d[i], v[i], fd[i], er[i], ep[i]);
            hold(a[i], s[i], 8);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL illegal_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 10; i++) begin
            hold(4'b1110, (i % 2 == 0) ? 7'h7E : 7'h30, 2);
        end
        hold(4'b1111, 7'h00, 3);
        total++;
        if (digits !== 16'h7648) begin bad++; $display("FAIL toggle_digits got=%h want=7648", digits); end
        total++;
        if (digit_valid !== 4'b1111) begin bad++; $display("FAIL toggle_valid got=%b want=1111", digit_valid); end
        hold(4'b1101, 7'h7E, S - 1);
        hold(4'b1111, 7'h00, 3);
        total++;
        if (digits !== 16'h7648) begin bad++; $display("FAIL short_hold_digits got=%h want=7648", digits); end
        push(cyc + S + 1, 16'h7608, 4'b1111, 1'b0, 1'b0, 2'd2);
        hold(4'b1101, 7'h7E, S + 2);
        hold(4'b1111, 7'h00, 3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL exact_hold_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_two_strobe();
        hold(4'b1100, 7'h7F, 10);
        hold(4'b1111, 7'h00, 2);
        total++;
        if (digits !== 16'h7608) begin bad++; $display("FAIL two_strobe_digits got=%h want=7608", digits); end
        total++;
        if (err_pos !== 2'd2) begin bad++; $display("FAIL two_strobe_err_pos got=%0d want=2", err_pos); end
    endtask

    task automatic test_reset_mid();
        int r;
        hold(4'b1110, 7'h30, 4);
        rst_n = 1'b0;
        #1;
        total++;
        if (digits !== 16'h0000) begin bad++; $display("FAIL mid_rst_digits got=%h want=0000", digits); end
        total++;
        if (digit_valid !== 4'b0000) begin bad++; $display("FAIL mid_rst_valid got=%b want=0000", digit_valid); end
        total++;
        if (err_pos !== 2'd0) begin bad++; $display("FAIL mid_rst_err_pos got=%0d want=0", err_pos); end
        total++;
        if (err !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL mid_rst_pulses got=%b%b want=00", err, frame_done);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        r = cyc;
        push(r + S + 1, 16'h0001, 4'b0001, 1'b0, 1'b0, 2'd0);
        repeat (S + 3) begin
            @(posedge clk);
            #1;
        end
        hold(4'b1111, 7'h00, 3);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL post_rst_pending got=%0d want=0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'h00;
        test_reset();
        test_single();
        test_scan();
        test_illegal();
        test_toggle();
        test_two_strobe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
